// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_stage
//  Purpose  : ID/EX ALU control stage. Decodes opcode/funct3/funct7 into the
//             ALU operation code and flags branches and unsupported encodings.
//             The decoded result sits in a one-entry valid/ready register with
//             stall and flush support.
//  Ports    : clk, reset (sync, active-high)
//             in_valid/in_ready, in_opcode, in_funct3, in_funct7, in_tag
//             flush
//             out_valid/out_ready, Operation, out_is_branch, out_illegal,
//             out_tag
//             cnt_total, cnt_branch, cnt_illegal (performance counters)
//  Config   : `define ALU_CTRL_PERF_CNT_EN builds the retire counters;
//             otherwise the counter ports are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_stage #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_is_branch,
    output logic                     out_illegal,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [31:0]              cnt_total,
    output logic [31:0]              cnt_branch,
    output logic [31:0]              cnt_illegal
);

    // ALU operation codes
    localparam logic [OPCODE_LENGTH-1:0] c_OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLL = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_NE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_GT  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLT = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRA = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRL = OPCODE_LENGTH'(4'b1111);

    // Major opcodes
    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_branch;
    logic                     dec_illegal;

    always_comb begin
        dec_op      = c_OP_AND;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (in_opcode)
            c_OPC_R: begin
                case (in_funct3)
                    3'b000: begin
                        if (in_funct7 == c_F7_BASE)     dec_op = c_OP_ADD;
                        else if (in_funct7 == c_F7_ALT) dec_op = c_OP_SUB;
                        else                            dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (in_funct7 == c_F7_BASE)     dec_op = c_OP_SRL;
                        else if (in_funct7 == c_F7_ALT) dec_op = c_OP_SRA;
                        else                            dec_illegal = 1'b1;
                    end
                    3'b011: dec_illegal = 1'b1;
                    default: begin
                        // Remaining R-type ops have no alternate funct7 form
                        if (in_funct7 != c_F7_BASE) begin
                            dec_illegal = 1'b1;
                        end else begin
                            case (in_funct3)
                                3'b111:  dec_op = c_OP_AND;
                                3'b110:  dec_op = c_OP_OR;
                                3'b100:  dec_op = c_OP_XOR;
                                3'b001:  dec_op = c_OP_SLL;
                                3'b010:  dec_op = c_OP_SLT;
                                default: dec_illegal = 1'b1;
                            endcase
                        end
                    end
                endcase
            end
            c_OPC_I: begin
                // funct7 only carries meaning for the shift-immediate forms
                case (in_funct3)
                    3'b000: dec_op = c_OP_ADD;
                    3'b101: begin
                        if (in_funct7 == c_F7_BASE || in_funct7 == c_F7_ALT)
                            dec_op = in_funct7[5] ? c_OP_SRA : c_OP_SRL;
                        else
                            dec_illegal = 1'b1;
                    end
                    3'b001: begin
                        if (in_funct7 == c_F7_BASE) dec_op = c_OP_SLL;
                        else                        dec_illegal = 1'b1;
                    end
                    3'b111:  dec_op = c_OP_AND;
                    3'b110:  dec_op = c_OP_OR;
                    3'b100:  dec_op = c_OP_XOR;
                    3'b010:  dec_op = c_OP_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            c_OPC_LOAD, c_OPC_STORE, c_OPC_JAL,
            c_OPC_JALR, c_OPC_LUI, c_OPC_AUIPC: begin
                dec_op = c_OP_ADD;
            end
            c_OPC_BRANCH: begin
                dec_branch = 1'b1;
                case (in_funct3)
                    3'b000:  dec_op = c_OP_EQ;
                    3'b001:  dec_op = c_OP_NE;
                    3'b100:  dec_op = c_OP_SLT;
                    3'b101:  dec_op = c_OP_GT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries travel with a neutral payload
        if (dec_illegal) begin
            dec_op     = '0;
            dec_branch = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // One-entry pipeline register
    // ------------------------------------------------------------------
    logic                     valid_q,   valid_d;
    logic [OPCODE_LENGTH-1:0] op_q,      op_d;
    logic                     branch_q,  branch_d;
    logic                     illegal_q, illegal_d;
    logic [TAG_WIDTH-1:0]     tag_q,     tag_d;

    logic load;
    logic retire;

    assign in_ready = !reset && !flush && (!valid_q || out_ready);
    assign load     = in_valid && in_ready;
    // A flushed entry is dropped, not retired
    assign retire   = valid_q && out_ready && !flush;

    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        tag_d     = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            op_d      = dec_op;
            branch_d  = dec_branch;
            illegal_d = dec_illegal;
            tag_d     = in_tag;
        end else if (retire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            tag_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            tag_q     <= tag_d;
        end
    end

    assign out_valid     = valid_q;
    assign Operation     = op_q;
    assign out_is_branch = branch_q;
    assign out_illegal   = illegal_q;
    assign out_tag       = tag_q;

    // ------------------------------------------------------------------
    // Retire counters
    // ------------------------------------------------------------------
`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] cnt_total_q,   cnt_total_d;
    logic [31:0] cnt_branch_q,  cnt_branch_d;
    logic [31:0] cnt_illegal_q, cnt_illegal_d;

    always_comb begin
        cnt_total_d   = cnt_total_q;
        cnt_branch_d  = cnt_branch_q;
        cnt_illegal_d = cnt_illegal_q;
        if (retire) begin
            cnt_total_d = cnt_total_q + 32'd1;
            if (branch_q)  cnt_branch_d  = cnt_branch_q + 32'd1;
            if (illegal_q) cnt_illegal_d = cnt_illegal_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_total_q   <= '0;
            cnt_branch_q  <= '0;
            cnt_illegal_q <= '0;
        end else begin
            cnt_total_q   <= cnt_total_d;
            cnt_branch_q  <= cnt_branch_d;
            cnt_illegal_q <= cnt_illegal_d;
        end
    end

    assign cnt_total   = cnt_total_q;
    assign cnt_branch  = cnt_branch_q;
    assign cnt_illegal = cnt_illegal_q;
`else
    assign cnt_total   = '0;
    assign cnt_branch  = '0;
    assign cnt_illegal = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_stage
//  Purpose  : Self-checking bench for alu_ctrl_stage. Directed scenarios plus
//             randomized traffic compared against a behavioural model of the
//             decode table and the one-entry handshake register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_stage;

    localparam int OPCODE_LENGTH = 4;
    localparam int TAG_WIDTH     = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [6:0]               in_opcode;
    logic [2:0]               in_funct3;
    logic [6:0]               in_funct7;
    logic [TAG_WIDTH-1:0]     in_tag;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     out_is_branch;
    logic                     out_illegal;
    logic [TAG_WIDTH-1:0]     out_tag;
    logic [31:0]              cnt_total;
    logic [31:0]              cnt_branch;
    logic [31:0]              cnt_illegal;

    alu_ctrl_stage #(
        .OPCODE_LENGTH (OPCODE_LENGTH),
        .TAG_WIDTH     (TAG_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7     (in_funct7),
        .in_tag        (in_tag),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Operation     (Operation),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal),
        .out_tag       (out_tag),
        .cnt_total     (cnt_total),
        .cnt_branch    (cnt_branch),
        .cnt_illegal   (cnt_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference decode: mnemonic-level table lookup
    // ------------------------------------------------------------------
    logic [3:0] alu_by_f3 [8];
    initial begin
        alu_by_f3[0] = 4'b0010; alu_by_f3[1] = 4'b0111; alu_by_f3[2] = 4'b1100;
        alu_by_f3[3] = 4'b0000; alu_by_f3[4] = 4'b0101; alu_by_f3[5] = 4'b1111;
        alu_by_f3[6] = 4'b0001; alu_by_f3[7] = 4'b0000;
    end

    task automatic ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           output logic [3:0] op, output logic br, output logic ill);
        bit plain, alt;
        plain = (f7 == 7'h00);
        alt   = (f7 == 7'h20);
        op = 4'b0000; br = 1'b0; ill = 1'b0;
        if (opc == 7'h33) begin
            if (f3 == 3'd3) ill = 1'b1;
            else if (f3 == 3'd0) begin
                if (plain) op = 4'b0010; else if (alt) op = 4'b0110; else ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (plain) op = 4'b1111; else if (alt) op = 4'b1110; else ill = 1'b1;
            end else if (!plain) ill = 1'b1;
            else op = alu_by_f3[f3];
        end else if (opc == 7'h13) begin
            if (f3 == 3'd3) ill = 1'b1;
            else if (f3 == 3'd5) begin
                if (plain) op = 4'b1111; else if (alt) op = 4'b1110; else ill = 1'b1;
            end else if (f3 == 3'd1 && !plain) ill = 1'b1;
            else op = alu_by_f3[f3];
        end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h6F ||
                     opc == 7'h67 || opc == 7'h37 || opc == 7'h17) begin
            op = 4'b0010;
        end else if (opc == 7'h63) begin
            br = 1'b1;
            if (f3 == 3'd0)      op = 4'b1000;
            else if (f3 == 3'd1) op = 4'b1001;
            else if (f3 == 3'd4) op = 4'b1100;
            else if (f3 == 3'd5) op = 4'b1010;
            else ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            op = 4'b0000;
            br = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Model of the held entry and counters
    // ------------------------------------------------------------------
    bit          m_valid;
    logic [3:0]  m_op;
    bit          m_br, m_ill;
    logic [4:0]  m_tag;
    bit          m_data_known;  // payload defined (valid entry or just reset)
    logic [31:0] m_total, m_branch, m_illegal;

    // One clock cycle: called at a negedge, returns at the next negedge
    task automatic step(input bit rst, input bit iv, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] tg,
                        input bit fl, input bit ordy);
        bit         exp_rdy;
        logic [3:0] d_op;
        bit         d_br, d_ill;
        reset = rst; in_valid = iv; in_opcode = opc; in_funct3 = f3;
        in_funct7 = f7; in_tag = tg; flush = fl; out_ready = ordy;
        #1;
        exp_rdy = !rst && !fl && (!m_valid || ordy);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        ref_dec(opc, f3, f7, d_op, d_br, d_ill);
        if (rst) begin
            m_valid = 0; m_op = 0; m_br = 0; m_ill = 0; m_tag = 0; m_data_known = 1;
            m_total = 0; m_branch = 0; m_illegal = 0;
        end else begin
            if (m_valid && ordy && !fl) begin
                m_total++;
                if (m_br)  m_branch++;
                if (m_ill) m_illegal++;
            end
            if (fl) begin
                m_valid = 0; m_data_known = 0;
            end else if (iv && exp_rdy) begin
                m_valid = 1; m_op = d_op; m_br = d_br; m_ill = d_ill; m_tag = tg;
                m_data_known = 1;
            end else if (m_valid && ordy) begin
                m_valid = 0; m_data_known = 0;
            end
        end
        @(negedge clk);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_data_known) begin
            check("Operation",     {28'b0, Operation},     {28'b0, m_op});
            check("out_is_branch", {31'b0, out_is_branch}, {31'b0, m_br});
            check("out_illegal",   {31'b0, out_illegal},   {31'b0, m_ill});
            check("out_tag",       {27'b0, out_tag},       {27'b0, m_tag});
        end
`ifdef ALU_CTRL_PERF_CNT_EN
        check("cnt_total",   cnt_total,   m_total);
        check("cnt_branch",  cnt_branch,  m_branch);
        check("cnt_illegal", cnt_illegal, m_illegal);
`else
        check("cnt_total",   cnt_total,   32'd0);
        check("cnt_branch",  cnt_branch,  32'd0);
        check("cnt_illegal", cnt_illegal, 32'd0);
`endif
    endtask

    logic [6:0] opc_pool [12];
    initial begin
        opc_pool[0] = 7'h33; opc_pool[1] = 7'h13; opc_pool[2]  = 7'h03; opc_pool[3]  = 7'h23;
        opc_pool[4] = 7'h6F; opc_pool[5] = 7'h67; opc_pool[6]  = 7'h37; opc_pool[7]  = 7'h17;
        opc_pool[8] = 7'h63; opc_pool[9] = 7'h73; opc_pool[10] = 7'h33; opc_pool[11] = 7'h63;
    end

    initial begin
        logic [31:0] snap_total;
        m_valid = 0; m_op = 0; m_br = 0; m_ill = 0; m_tag = 0; m_data_known = 0;
        m_total = 0; m_branch = 0; m_illegal = 0;

        // Reset held two cycles with a pending instruction
        step(1, 1, 7'h33, 3'd0, 7'h00, 5'd1, 0, 1);
        step(1, 1, 7'h33, 3'd0, 7'h00, 5'd1, 0, 1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_op",    {28'b0, Operation}, 32'd0);

        // Back-to-back: add, sub, srai, bge
        step(0, 1, 7'h33, 3'd0, 7'h00, 5'd2, 0, 1);
        check("b2b_add", {28'b0, Operation}, 32'h2);
        step(0, 1, 7'h33, 3'd0, 7'h20, 5'd3, 0, 1);
        check("b2b_sub", {28'b0, Operation}, 32'h6);
        step(0, 1, 7'h13, 3'd5, 7'h20, 5'd4, 0, 1);
        check("b2b_srai", {28'b0, Operation}, 32'hE);
        check("b2b_srai_br", {31'b0, out_is_branch}, 32'd0);
        step(0, 1, 7'h63, 3'd5, 7'h00, 5'd5, 0, 1);
        check("b2b_bge", {28'b0, Operation}, 32'hA);
        check("b2b_bge_br", {31'b0, out_is_branch}, 32'd1);

        // Illegal encodings after a fresh reset
        step(1, 0, 7'h00, 3'd0, 7'h00, 5'd0, 0, 1);
        step(0, 1, 7'h33, 3'd3, 7'h00, 5'd6, 0, 1);
        check("ill_sltu", {31'b0, out_illegal}, 32'd1);
        step(0, 1, 7'h73, 3'd0, 7'h00, 5'd7, 0, 1);
        check("ill_sys", {31'b0, out_illegal}, 32'd1);
        check("ill_sys_op", {28'b0, Operation}, 32'd0);
        step(0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 0, 1);
`ifdef ALU_CTRL_PERF_CNT_EN
        check("ill_cnt_illegal", cnt_illegal, 32'd2);
        check("ill_cnt_total",   cnt_total,   32'd2);
`endif

        // Stall three cycles with a new instruction waiting, then release
        step(0, 1, 7'h33, 3'd7, 7'h00, 5'd8, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 7'h33, 3'd6, 7'h00, 5'd9, 0, 0);
            check("stall_op",  {28'b0, Operation}, 32'h0);
            check("stall_tag", {27'b0, out_tag},   32'd8);
        end
        step(0, 1, 7'h33, 3'd6, 7'h00, 5'd9, 0, 1);
        check("stall_new_op", {28'b0, Operation}, 32'h1);

        // Flush with a valid entry and a consumer ready
        snap_total = cnt_total;
        step(0, 1, 7'h33, 3'd4, 7'h00, 5'd10, 1, 1);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_cnt", cnt_total, snap_total);

        // Reset in the middle of a stall
        step(0, 1, 7'h63, 3'd0, 7'h00, 5'd11, 0, 1);
        step(0, 1, 7'h13, 3'd0, 7'h00, 5'd12, 0, 0);
        step(1, 1, 7'h13, 3'd0, 7'h00, 5'd12, 0, 0);

`ifdef ALU_CTRL_PERF_CNT_EN
        // Counter wrap
        step(0, 1, 7'h03, 3'd2, 7'h00, 5'd13, 0, 0);
        force dut.cnt_total_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_total_q;
        m_total = 32'hFFFF_FFFF;
        step(0, 0, 7'h00, 3'd0, 7'h00, 5'd0, 0, 1);
        check("wrap_total", cnt_total, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [6:0] r_f7;
            int sel;
            sel  = int'($urandom_range(0, 3));
            r_f7 = (sel == 0) ? 7'($urandom) : ((sel == 1) ? 7'h20 : 7'h00);
            step(($urandom_range(0, 63) == 0),
                 bit'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_pool[$urandom_range(0, 11)],
                 3'($urandom), r_f7, 5'($urandom),
                 ($urandom_range(0, 15) == 0),
                 bit'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ALU control stage sitting at the ID/EX boundary of the RISC-V core. It accepts decoded instruction fields from the decode stage, translates opcode/funct3/funct7 into the 4-bit ALU operation code, and flags branches and unsupported encodings. Result, branch flag and illegal flag are held in a one-entry valid/ready pipeline register with stall and flush support. This is the producer end of the ALU's `Operation` input.

## Interface
- `OPCODE_LENGTH`, 4, width of the ALU operation code.
- `TAG_WIDTH`, 5, width of the opaque tag (destination register) carried alongside.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opcode`  in  7  instruction bits [6:0].
- `in_funct3`  in  3  instruction bits [14:12].
- `in_funct7`  in  7  instruction bits [31:25].
- `in_tag`  in  TAG_WIDTH  passed through unchanged.
- `flush`  in  1  discard the held entry and block acceptance this cycle.
- `out_valid`  out  1  registered entry is valid.
- `out_ready`  in  1  execute stage consumes the entry.
- `Operation`  out  OPCODE_LENGTH  ALU operation code.
- `out_is_branch`  out  1  entry is a conditional branch.
- `out_illegal`  out  1  encoding unsupported; `Operation` forced to 4'b0000.
- `out_tag`  out  TAG_WIDTH  registered tag.
- `cnt_total`, `cnt_branch`, `cnt_illegal`  out  32 each  performance counters (see Configuration).

## Operation
- Operation codes: AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLL 0111, EQ 1000, NE 1001, GT 1010, SLT 1100, SRA 1110, SRL 1111.
- R-type (0110011), by funct3:
  - 000: ADD if funct7=0000000, SUB if 0100000.
  - 111 AND, 110 OR, 100 XOR, 001 SLL, 010 SLT.
  - 101: SRL if funct7=0000000, SRA if 0100000.
  - funct7=0100000 with funct3 not in {000,101}, any other funct7, or funct3=011: illegal.
- I-type ALU (0010011): same funct3 mapping, but 000 is always ADD.
  - 101: SRL/SRA chosen by funct7[5]; funct7 other than 0000000/0100000 is illegal.
  - 001: requires funct7=0000000; otherwise illegal.
  - funct3=011: illegal.
- Load (0000011), store (0100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111): ADD.
- Branch (1100011): BEQ(000) EQ, BNE(001) NE, BLT(100) SLT, BGE(101) GT. `is_branch`=1. Other funct3 values: illegal, and `is_branch`=0.
- Any other opcode: illegal.
- Illegal entries still flow through the handshake with `Operation`=0000 and `is_branch`=0.
- Handshake:
  - `in_ready` = !flush && (!out_valid || out_ready).
  - Load occurs when in_valid && in_ready.
  - Entry retires when out_valid && out_ready.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on outputs after edge N.
- Throughput 1 per cycle while `out_ready`=1. Load and retire in the same cycle replace the entry without a bubble.
- Stall (out_valid=1, out_ready=0): all outputs hold stable; `in_ready`=0.
- Flush: `out_valid`=0 after the edge. Nothing is loaded. Data outputs may retain stale values. A held entry is dropped even if `out_ready`=1 in the same cycle, and it is not counted.
- Reset (also mid-stall or mid-flush) has priority over everything:
  - `out_valid`, `out_is_branch`, `out_illegal` = 0.
  - `Operation` = 0000, `out_tag` = 0.
  - Counters = 0.
- `in_ready` = 0 while reset is asserted.

## Configuration
- `ALU_CTRL_PERF_CNT_EN` defined:
  - `cnt_total` increments on every retire (out_valid && out_ready && !flush).
  - `cnt_branch` increments on retires with is_branch=1.
  - `cnt_illegal` increments on retires with illegal=1.
  - All counters are 32-bit, wrap from FFFF_FFFF to 0, and clear on reset.
- Not defined: the counter ports remain and are driven constant 0, and no counter flops are built.

## Test plan
- Reset check: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, Operation=0000, all counters 0.
- Back-to-back decode, out_ready=1:
  - Present add (0110011/000/0000000), sub (0100000), srai (0010011/101/0100000), bge (1100011/101).
  - Expect Operation 0010, 0110, 1110, 1010 on consecutive cycles, with out_is_branch=1 only on the last.
- Illegal encodings: sltu (0110011/011) and opcode 1110011.
  - Expect out_illegal=1, Operation=0000.
  - With the macro on, cnt_illegal=2 and cnt_total=2.
- Stall: out_ready=0 for 3 cycles with a new in_valid presented -> outputs frozen, in_ready=0. Release -> held op retires, then the new op appears next cycle.
- Flush with out_valid=1, out_ready=1, in_valid=1 -> next cycle out_valid=0, the input is not accepted, and counters are unchanged.
- Counter wrap (macro on, cnt_total preloaded via force to FFFF_FFFF) -> one retire gives 0000_0000.
